// File: rtl/rx_stm.sv
// UART receive state machine: oversampled start detection, 8 data bits LSB first,
// optional parity, one or two stop bits, and sticky error reporting on FIFO hand-off.
module rx_stm #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Cfg_ctrl_Rx_en,
   input  logic       Cfg_ctrl_stopbit,
   input  logic [1:0] Cfg_ctrl_paritybit,
   input  logic       Cfg_ctrl_err_clr,
   input  logic       Baud_ctrl_tick,
   input  logic       Rx_data_in,
   input  logic       FIFO_ctrl_full,
   output logic       STM_ctrl_FIFO_w_en,
   output logic [7:0] STM_data_payload,
   output logic       STM_stat_parity_err,
   output logic       STM_stat_frame_err,
   output logic       STM_stat_overrun,
   output logic       STM_stat_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            rx_meta_q, rxs_q;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [2:0]      bidx_q, bidx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic            stop2_q, stop2_d;
   logic [1:0]      par_q, par_d;
   logic            pe_q, pe_d;
   logic            fe_q, fe_d;
   logic            ov_q, ov_d;

   logic            samp;
   logic            par_en;
   logic            done_v;

   assign samp   = Baud_ctrl_tick && (tcnt_q == TC_LAST);
   assign par_en = (par_q == 2'b01) || (par_q == 2'b10);
   // A frame aborted by Rx_en in its DONE cycle neither writes nor flags.
   assign done_v = (state_q == S_DONE) && Cfg_ctrl_Rx_en;

   // Synchronizer idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= Rx_data_in;
         rxs_q     <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!Cfg_ctrl_Rx_en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (!rxs_q) state_d = S_START;
            S_START:  if (Baud_ctrl_tick && (tcnt_q == TC_HALF))
                         state_d = rxs_q ? S_IDLE : S_DATA;
            S_DATA:   if (samp && (bidx_q == 3'd7))
                         state_d = par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (samp) state_d = S_STOP1;
            S_STOP1:  if (samp) state_d = stop2_q ? S_STOP2 : S_DONE;
            S_STOP2:  if (samp) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      tcnt_d  = tcnt_q;
      bidx_d  = bidx_q;
      shreg_d = shreg_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      stop2_d = stop2_q;
      par_d   = par_q;

      if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_DONE)) begin
         tcnt_d = '0;
      end else if (Baud_ctrl_tick) begin
         tcnt_d = (tcnt_q == TC_LAST) ? '0 : tcnt_q + 1'b1;
      end

      if ((state_q == S_IDLE) && (state_d == S_START)) begin
         stop2_d = Cfg_ctrl_stopbit;
         par_d   = Cfg_ctrl_paritybit;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
      end

      if ((state_q == S_START) && (state_d == S_DATA)) begin
         bidx_d = 3'd0;
      end

      if (samp) begin
         case (state_q)
            S_DATA: begin
               shreg_d = {rxs_q, shreg_q[7:1]};
               bidx_d  = bidx_q + 3'd1;
            end
            // Odd mode wants an odd total of ones, even mode an even total.
            S_PARITY: perr_d = (par_q == 2'b01) ? ~(^shreg_q ^ rxs_q) : (^shreg_q ^ rxs_q);
            S_STOP1, S_STOP2: if (!rxs_q) ferr_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q  <= '0;
         bidx_q  <= 3'd0;
         shreg_q <= 8'h00;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         stop2_q <= 1'b0;
         par_q   <= 2'b00;
      end else begin
         tcnt_q  <= tcnt_d;
         bidx_q  <= bidx_d;
         shreg_q <= shreg_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         stop2_q <= stop2_d;
         par_q   <= par_d;
      end
   end

   // Set wins over clear when both land in the same cycle.
   always_comb begin
      pe_d = (pe_q & ~Cfg_ctrl_err_clr) | (done_v & perr_q);
      fe_d = (fe_q & ~Cfg_ctrl_err_clr) | (done_v & ferr_q);
      ov_d = (ov_q & ~Cfg_ctrl_err_clr) | (done_v & FIFO_ctrl_full);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_q <= 1'b0;
         fe_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         pe_q <= pe_d;
         fe_q <= fe_d;
         ov_q <= ov_d;
      end
   end

   always_comb begin
      STM_stat_busy       = (state_q != S_IDLE);
      STM_ctrl_FIFO_w_en  = done_v & ~perr_q & ~ferr_q & ~FIFO_ctrl_full;
      STM_data_payload    = shreg_q;
      STM_stat_parity_err = pe_q;
      STM_stat_frame_err  = fe_q;
      STM_stat_overrun    = ov_q;
   end

endmodule

// File: tb/tb_rx_stm.sv
// Directed bench for rx_stm: 16x oversampling with a tick every 4 clks,
// serial frames driven bit by bit, FIFO writes captured by a monitor.
module tb_rx_stm;

   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_en, cfg_stop, err_clr, tick, rx, full;
   logic [1:0] cfg_par;
   logic       w_en, busy, pe, fe, ov;
   logic [7:0] payload;

   int         nchk  = 0;
   int         npass = 0;
   int         wcnt  = 0;
   logic [7:0] last_pl = 8'h00;
   logic [1:0] div = 2'd0;

   rx_stm #(.OVERSAMPLE(16)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .Cfg_ctrl_Rx_en      (rx_en),
      .Cfg_ctrl_stopbit    (cfg_stop),
      .Cfg_ctrl_paritybit  (cfg_par),
      .Cfg_ctrl_err_clr    (err_clr),
      .Baud_ctrl_tick      (tick),
      .Rx_data_in          (rx),
      .FIFO_ctrl_full      (full),
      .STM_ctrl_FIFO_w_en  (w_en),
      .STM_data_payload    (payload),
      .STM_stat_parity_err (pe),
      .STM_stat_frame_err  (fe),
      .STM_stat_overrun    (ov),
      .STM_stat_busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      div  = div + 2'd1;
      tick = (div == 2'd0);
   end

   always @(posedge clk) begin
      #1;
      if (w_en === 1'b1) begin
         wcnt    = wcnt + 1;
         last_pl = payload;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                             input int nstop, input logic stop_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (has_par) drive_bit(pbit);
      for (int s = 0; s < nstop; s++) begin
         if (stop_v) drive_bit(1'b1);
         else begin
            // Low only past the centre sample so the tail reads as a short glitch.
            rx = 1'b0;
            repeat (40) @(negedge clk);
            rx = 1'b1;
            repeat (BIT_CLKS - 40) @(negedge clk);
         end
      end
      rx = 1'b1;
      repeat (100) @(negedge clk);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_to_bit4();
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      int wexp;
      rst_n = 1'b0; rx_en = 1'b0; cfg_stop = 1'b0; cfg_par = 2'b00;
      err_clr = 1'b0; rx = 1'b1; full = 1'b0; tick = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_w_en", w_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_payload", payload, 0);
      chk("rst_flags", {pe, fe, ov}, 0);
      rst_n = 1'b1;
      rx_en = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_busy", busy, 0);

      // 8N1 0xA5
      send_frame(8'hA5, 0, 1'b0, 1, 1'b1);
      chk("8n1_wcnt", wcnt, 1);
      chk("8n1_payload", last_pl, 8'hA5);
      chk("8n1_flags", {pe, fe, ov}, 0);

      // 8O2 0x3C: four ones, odd parity bit = 1
      cfg_stop = 1'b1; cfg_par = 2'b01;
      send_frame(8'h3C, 1, 1'b1, 2, 1'b1);
      chk("8o2_wcnt", wcnt, 2);
      chk("8o2_payload", last_pl, 8'h3C);
      chk("8o2_pe", pe, 0);
      send_frame(8'h3C, 1, 1'b0, 2, 1'b1);
      chk("8o2_bad_wcnt", wcnt, 2);
      chk("8o2_bad_pe", pe, 1);
      chk("8o2_bad_fe", fe, 0);
      pulse_clr();
      chk("8o2_clr_pe", pe, 0);

      // 8E1 0x01, even parity bit = 1, stop forced low
      cfg_stop = 1'b0; cfg_par = 2'b10;
      send_frame(8'h01, 1, 1'b1, 1, 1'b0);
      chk("8e1_wcnt", wcnt, 2);
      chk("8e1_fe", fe, 1);
      chk("8e1_pe", pe, 0);
      pulse_clr();
      chk("8e1_clr_fe", fe, 0);

      // Start glitch of 5 ticks
      cfg_par = 2'b00;
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch_wcnt", wcnt, 2);
      chk("glitch_busy", busy, 0);
      chk("glitch_flags", {pe, fe, ov}, 0);

      // Overrun on a valid 0x55 frame
      full = 1'b1;
      send_frame(8'h55, 0, 1'b0, 1, 1'b1);
      full = 1'b0;
      chk("ovr_wcnt", wcnt, 2);
      chk("ovr_ov", ov, 1);
      chk("ovr_pe_fe", {pe, fe}, 0);
      send_frame(8'h96, 0, 1'b0, 1, 1'b1);
      chk("ovr_next_wcnt", wcnt, 3);
      chk("ovr_next_payload", last_pl, 8'h96);
      chk("ovr_sticky", ov, 1);

      // Rx_en dropped during bit 4
      wexp = wcnt;
      start_to_bit4();
      chk("en_mid_busy", busy, 1);
      rx_en = 1'b0;
      @(negedge clk);
      chk("en_abort_busy", busy, 0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rx_en = 1'b1;
      repeat (100) @(negedge clk);
      chk("en_abort_wcnt", wcnt, wexp);
      chk("en_abort_flags", {pe, fe}, 0);
      send_frame(8'hFF, 0, 1'b0, 1, 1'b1);
      chk("en_ff_wcnt", wcnt, wexp + 1);
      chk("en_ff_payload", last_pl, 8'hFF);

      // rst_n asserted during bit 4
      wexp = wcnt;
      start_to_bit4();
      chk("rst_mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_abort_busy", busy, 0);
      chk("rst_abort_payload", payload, 0);
      chk("rst_abort_ov", ov, 0);
      @(negedge clk);
      rx = 1'b1;
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("rst_abort_wcnt", wcnt, wexp);
      send_frame(8'hFF, 0, 1'b0, 1, 1'b1);
      chk("rst_ff_wcnt", wcnt, wexp + 1);
      chk("rst_ff_payload", last_pl, 8'hFF);
      chk("rst_ff_flags", {pe, fe, ov}, 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/rx_stm.md
RX_STM -- requirements
Module: rx_stm

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: Baud_ctrl_tick pulses per bit period; even value, 8..32.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports: clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset).
REQ-003 SHALL have port Cfg_ctrl_Rx_en  in  1  receiver enable.
REQ-004 SHALL have port Cfg_ctrl_stopbit  in  1  0 = one stop bit, 1 = two stop bits.
REQ-005 SHALL have port Cfg_ctrl_paritybit  in  2  00 none, 01 odd, 10 even, 11 none.
REQ-006 SHALL have port Cfg_ctrl_err_clr  in  1  clears the sticky error flags.
REQ-007 SHALL have port Baud_ctrl_tick  in  1  one-clk oversample strobe.
REQ-008 SHALL have port Rx_data_in  in  1  asynchronous serial line, idle high.
REQ-009 SHALL have port FIFO_ctrl_full  in  1  receive FIFO full.
REQ-010 SHALL have port STM_ctrl_FIFO_w_en  out  1  one-clk FIFO write strobe.
REQ-011 SHALL have port STM_data_payload  out  8  received byte, valid while w_en is high.
REQ-012 SHALL have ports STM_stat_parity_err, STM_stat_frame_err and STM_stat_overrun  out  1 each  sticky error flags.
REQ-013 SHALL have port STM_stat_busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL pass Rx_data_in through a 2-flop synchronizer; all sampling below uses the synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
REQ-016 SHALL keep a tick counter tcnt, counting 0..OVERSAMPLE-1, that advances only on Baud_ctrl_tick and is cleared on every state entry.
REQ-017 SHALL move from IDLE to START when Cfg_ctrl_Rx_en=1 and rxs=0; rxs=1 keeps IDLE.
REQ-018 START: on the tick with tcnt=OVERSAMPLE/2-1, SHALL go to DATA if rxs=0; if rxs=1 (glitch), SHALL return to IDLE with no flag and no write.
REQ-019 DATA, PARITY, STOP1, STOP2: SHALL sample rxs on the tick with tcnt=OVERSAMPLE-1, which is the bit centre.
REQ-020 DATA: SHALL shift the 8 bits in LSB first using a 3-bit index; after bit 7 it SHALL go to PARITY if parity is enabled, otherwise to STOP1.
REQ-021 PARITY: SHALL set perr_frame=1 when the sampled bit does not match the parity of the data: odd (01) means data plus parity has an odd number of ones, even (10) means an even number.
REQ-022 STOP1: sampled rxs=0 SHALL set ferr_frame; then go to STOP2 if Cfg_ctrl_stopbit=1, else to DONE.
REQ-023 STOP2: sampled rxs=0 SHALL set ferr_frame; then go to DONE.
REQ-024 DONE SHALL last exactly one clk, then return to IDLE; a start edge SHALL be detectable in the following cycle.
REQ-025 DONE: STM_ctrl_FIFO_w_en=1 SHALL occur only if perr_frame=0, ferr_frame=0 and FIFO_ctrl_full=0.
REQ-026 DONE with FIFO_ctrl_full=1 SHALL set STM_stat_overrun and drop the byte.
REQ-027 DONE with perr_frame=1 SHALL set STM_stat_parity_err and drop the byte.
REQ-028 DONE with ferr_frame=1 SHALL set STM_stat_frame_err and drop the byte.
REQ-029 When several error conditions coincide, all applicable flags SHALL set.
REQ-030 Write latency: w_en SHALL rise 1 clk after the last stop-bit sampling tick.
REQ-031 SHALL drive STM_data_payload from the shift register at all times, while only the w_en cycle is meaningful.
REQ-032 Sticky flags SHALL hold until Cfg_ctrl_err_clr=1, which clears them on the next clk.
REQ-033 A set and a clear in the same cycle SHALL leave the flag set.
REQ-034 Cfg_ctrl_Rx_en=0 in any state SHALL force IDLE on the next clk: the frame is aborted, with no write and no flag.
REQ-035 Cfg_ctrl_stopbit and Cfg_ctrl_paritybit SHALL be latched on IDLE->START and held for the whole frame.
REQ-036 Missing ticks SHALL stall the FSM indefinitely; there is no timeout.

Reset
REQ-037 rst_n=0 SHALL asynchronously force: state=IDLE, tcnt=0, bit index=0, shift register=0x00, synchronizer flops=1.
REQ-038 rst_n=0 SHALL asynchronously force all outputs to 0.
REQ-039 Reset mid-frame SHALL discard the partial byte; after release the FSM SHALL wait for a new falling edge.

Verification
REQ-040 SHALL cover: 8N1, send 0xA5 -> one w_en, payload 0xA5, all flags 0.
REQ-041 SHALL cover: 8O2, send 0x3C with parity bit 1 -> payload 0x3C written; same frame with parity bit 0 -> no write, parity_err=1.
REQ-042 SHALL cover: 8E1, send 0x01 with stop bit forced 0 -> no write, frame_err=1; then pulse err_clr -> frame_err=0.
REQ-043 SHALL cover: low pulse on Rx_data_in shorter than OVERSAMPLE/2 ticks -> START returns to IDLE, no write, flags 0.
REQ-044 SHALL cover: FIFO_ctrl_full=1 during DONE of a valid 0x55 frame -> no write, overrun=1; the next frame with full=0 writes normally.
REQ-045 SHALL cover: Rx_en dropped, or rst_n asserted, during DATA bit 4 -> IDLE on the next clk, no write; a subsequent 0xFF frame is received correctly.
